// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default width and shifter modes.
// Imported by alu_unit, alu_shifter and the control unit.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;
  localparam logic [3:0] ALU_PASSA = 4'b1011;

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_PASS = 2'b11
  } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for SLL / SRL / SRA; only the low 4 bits of the amount are used.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       shamt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (shift_mode_e'(mode))
      SH_SLL:  dout = din << shamt;
      SH_SRL:  dout = din >> shamt;
      SH_SRA:  dout = $signed(din) >>> shamt;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// 16-bit datapath ALU with zero/positive flags. Combinational by default;
// defining ALU_OUT_REG_EN registers out/zero/pos for one cycle of latency.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int OPW   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OPW-1:0]   inst_id,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             pos
);

  logic [WIDTH-1:0] out_d;
  logic             zero_d;
  logic             pos_d;
  logic [WIDTH-1:0] shift_res;
  logic [1:0]       sh_mode;
  logic             slt_w;
  logic             sltu_w;

  always_comb begin
    sh_mode = SH_PASS;
    case (inst_id)
      ALU_SLL: sh_mode = SH_SLL;
      ALU_SRL: sh_mode = SH_SRL;
      ALU_SRA: sh_mode = SH_SRA;
      default: sh_mode = SH_PASS;
    endcase
  end

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .din   (in0),
    .shamt (in1[3:0]),
    .mode  (sh_mode),
    .dout  (shift_res)
  );

  assign slt_w  = $signed(in0) < $signed(in1);
  assign sltu_w = in0 < in1;

  always_comb begin
    out_d = '0;
    case (inst_id)
      ALU_ADD:   out_d = in0 + in1;
      ALU_SUB:   out_d = in0 - in1;
      ALU_AND:   out_d = in0 & in1;
      ALU_OR:    out_d = in0 | in1;
      ALU_XOR:   out_d = in0 ^ in1;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:   out_d = shift_res;
      ALU_SLT:   out_d = WIDTH'(slt_w);
      ALU_SLTU:  out_d = WIDTH'(sltu_w);
      ALU_PASSB: out_d = in1;
      ALU_PASSA: out_d = in0;
      default:   out_d = '0;
    endcase
  end

  // Flags derive from the same pre-register result so they stay coherent with out.
  always_comb begin
    zero_d = (out_d == '0);
    pos_d  = ~out_d[WIDTH-1] & (out_d != '0);
  end

`ifdef ALU_OUT_REG_EN
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             pos_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      zero_q <= 1'b0;
      pos_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      zero_q <= zero_d;
      pos_q  <= pos_d;
    end
  end

  assign out  = out_q;
  assign zero = zero_q;
  assign pos  = pos_q;
`else
  logic unused_clock;
  assign unused_clock = clock;

  // Reset masks the flags too, so zero reads low even though out is 0.
  assign out  = reset ? '0 : out_d;
  assign zero = ~reset & zero_d;
  assign pos  = ~reset & pos_d;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Directed scoreboard bench for alu_unit; follows ALU_OUT_REG_EN for output latency.
module tb_alu_unit;
  import alu_pkg::*;

  logic        clock;
  logic        reset;
  logic [3:0]  inst_id;
  logic [15:0] in0;
  logic [15:0] in1;
  logic [15:0] out;
  logic        zero;
  logic        pos;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] out;
    logic        zero;
    logic        pos;
    string       tag;
  } exp_t;

  exp_t sb[$];

  alu_unit #(
    .WIDTH (16),
    .OPW   (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .inst_id (inst_id),
    .in0     (in0),
    .in1     (in1),
    .out     (out),
    .zero    (zero),
    .pos     (pos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic push_raw(input string tag, input logic [15:0] o, input logic z, input logic p);
    exp_t e;
    e.out = o; e.zero = z; e.pos = p; e.tag = tag;
    sb.push_back(e);
  endtask

  // Flags follow from the expected value: zero when 0, pos when signed > 0.
  task automatic push_res(input string tag, input logic [15:0] o);
    push_raw(tag, o, (o == 16'h0000), ($signed(o) > 0));
  endtask

  task automatic settle();
`ifdef ALU_OUT_REG_EN
    @(posedge clock);
    #1;
`else
    #1;
`endif
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty got=none exp=entry");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (out === e.out) else begin
      failures++;
      $error("FAIL %s.out got=%h exp=%h", e.tag, out, e.out);
    end
    checks++;
    assert (zero === e.zero) else begin
      failures++;
      $error("FAIL %s.zero got=%b exp=%b", e.tag, zero, e.zero);
    end
    checks++;
    assert (pos === e.pos) else begin
      failures++;
      $error("FAIL %s.pos got=%b exp=%b", e.tag, pos, e.pos);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] exp_out);
    @(negedge clock);
    inst_id = op;
    in0     = a;
    in1     = b;
    push_res(tag, exp_out);
    settle();
    check_front();
  endtask

  initial begin
    reset   = 1'b1;
    inst_id = ALU_ADD;
    in0     = 16'd5;
    in1     = 16'd3;

    // Reset held with live operands: everything forced low.
    @(negedge clock);
    push_raw("rst_hold", 16'h0000, 1'b0, 1'b0);
    #1;
    check_front();

    reset = 1'b0;
`ifdef ALU_OUT_REG_EN
    push_raw("rst_release_pre", 16'h0000, 1'b0, 1'b0);
    #1;
    check_front();
`endif
    push_raw("rst_release", 16'h0008, 1'b0, 1'b1);
    settle();
    check_front();

    step("add_pc",      ALU_ADD,  16'h0010, 16'h0002, 16'h0012);
    step("add_wrap",    ALU_ADD,  16'hFFFF, 16'h0001, 16'h0000);
    step("sub_eq",      ALU_SUB,  16'h1234, 16'h1234, 16'h0000);
    step("sub_neg",     ALU_SUB,  16'h0003, 16'h0005, 16'hFFFE);
    step("sub_pos",     ALU_SUB,  16'h0005, 16'h0003, 16'h0002);
    step("sll_15",      ALU_SLL,  16'h0001, 16'h000F, 16'h8000);
    step("srl_4",       ALU_SRL,  16'h8000, 16'h0004, 16'h0800);
    step("sra_4",       ALU_SRA,  16'h8000, 16'h0004, 16'hF800);
    step("sra_pos",     ALU_SRA,  16'h4000, 16'h0004, 16'h0400);
    step("sll_hi_amt",  ALU_SLL,  16'h0001, 16'h0013, 16'h0008);
    step("srl_0",       ALU_SRL,  16'h8001, 16'h0000, 16'h8001);
    step("slt_neg",     ALU_SLT,  16'hFFFF, 16'h0001, 16'h0001);
    step("sltu_big",    ALU_SLTU, 16'hFFFF, 16'h0001, 16'h0000);
    step("slt_rev",     ALU_SLT,  16'h0001, 16'hFFFF, 16'h0000);
    step("sltu_rev",    ALU_SLTU, 16'h0001, 16'hFFFF, 16'h0001);
    step("and",         ALU_AND,  16'hF0F0, 16'h0FF0, 16'h00F0);
    step("or",          ALU_OR,   16'hF0F0, 16'h0FF0, 16'hFFF0);
    step("xor",         ALU_XOR,  16'hF0F0, 16'h0FF0, 16'hFF00);
    step("passb",       ALU_PASSB,16'h7FFF, 16'h8001, 16'h8001);
    step("passa",       ALU_PASSA,16'h7FFF, 16'h8001, 16'h7FFF);

    for (int unsigned op = 12; op < 16; op++) begin
      step($sformatf("undef_%0d", op), 4'(op), 16'h1234, 16'h5678, 16'h0000);
    end

    // Back-to-back results exercise the pipeline ordering of the scoreboard.
    step("b2b_a",       ALU_ADD,  16'h0100, 16'h0023, 16'h0123);
    step("b2b_b",       ALU_SUB,  16'h0000, 16'h0001, 16'hFFFF);

    // Reset asserted mid-stream must clear outputs without a clock edge.
    step("pre_mid_rst", ALU_ADD,  16'h0005, 16'h0003, 16'h0008);
    #1;
    reset = 1'b1;
    push_raw("mid_rst", 16'h0000, 1'b0, 1'b0);
    #1;
    check_front();
    @(negedge clock);
    reset = 1'b0;
    push_raw("mid_rst_release", 16'h0008, 1'b0, 1'b1);
    settle();
    check_front();

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 16-bit integer ALU used as the main datapath ALU and as the PC incrementer in the single-cycle core.
- Takes a 4-bit operation code and two operands. Produces a result, a zero flag and a positive flag.
- Combinational by default. An optional output register adds one cycle of latency.

Parameters:
- WIDTH, 16: operand and result width in bits.
- OPW, 4: width of the operation code.

Ports:
- clock  input  1  system clock; used only when the output register is compiled in.
- reset  input  1  asynchronous, active-high reset.
- inst_id  input  OPW  operation select.
- in0  input  WIDTH  operand A.
- in1  input  WIDTH  operand B.
- out  output  WIDTH  result.
- zero  output  1  high when the result equals 0.
- pos  output  1  high when the result, read as signed, is greater than 0.

Behaviour:
- Opcode map (any other code gives result 0):
  - 0000 ADD: in0+in1, modulo 2^WIDTH, carry discarded.
  - 0001 SUB: in0-in1, modulo 2^WIDTH.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SLL: in0 << in1[3:0].
  - 0110 SRL: logical right shift by in1[3:0].
  - 0111 SRA: arithmetic right shift by in1[3:0], sign-filled.
  - 1000 SLT: 1 if signed in0 < signed in1, else 0.
  - 1001 SLTU: 1 if unsigned in0 < in1, else 0.
  - 1010 PASSB: in1.
  - 1011 PASSA: in0.
- zero = (result == 0).
- pos = ~result[WIDTH-1] & (result != 0). zero and pos are never both high.
- Overflow is not flagged. ADD 0xFFFF+1 gives out=0, zero=1.
- Shift amount 0 passes in0 unchanged. Shift amount above 15 cannot occur because only in1[3:0] is used.
- Default build: fully combinational, zero latency.
  - reset high forces out=0, zero=0 and pos=0 immediately, regardless of inputs.
  - When reset is released, outputs follow the inputs in the same cycle.
- Callers depend on the zero-latency path: PC+2 and the branch compare must settle within one cycle.

Optional Feature:
- ALU_OUT_REG_EN defined:
  - out, zero and pos are registered on posedge clock. Latency is 1 cycle.
  - Asynchronous reset clears all three to 0.
  - The register updates on every clock edge while reset is low. There is no enable.
  - zero and pos are computed from the same pre-register result as out, so they stay coherent with out.
- ALU_OUT_REG_EN undefined:
  - Combinational behaviour as described above. clock is left unconnected internally.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams ALU_ADD .. ALU_PASSA, with values as in the map;
  - WIDTH_DEFAULT = 16.
- The control unit imports the same package.
- One natural sub-module: alu_shifter (SLL/SRL/SRA barrel shifter, selected by a 2-bit mode).
- Flag generation and the optional register stay in alu_unit.

Test Plan:
- Reset: assert reset with in0=5, in1=3, ADD -> out=0, zero=0, pos=0. Deassert -> out=8, pos=1, in the same cycle (the next cycle with ALU_OUT_REG_EN).
- PC increment: ADD in0=0x0010, in1=2 -> out=0x0012. ADD 0xFFFF+1 -> out=0x0000, zero=1, pos=0.
- Branch compare:
  - SUB 0x1234-0x1234 -> out=0, zero=1.
  - SUB 3-5 -> out=0xFFFE, zero=0, pos=0.
  - SUB 5-3 -> out=2, pos=1.
- Shifts:
  - SLL 0x0001 by 15 -> 0x8000.
  - SRL 0x8000 by 4 -> 0x0800.
  - SRA 0x8000 by 4 -> 0xF800.
  - SLL with in1=0x0013 -> shift by 3.
- Compares and logic:
  - SLT 0xFFFF vs 0x0001 -> 1. SLTU with the same operands -> 0.
  - AND 0xF0F0 with 0x0FF0 -> 0x00F0. OR -> 0xFFF0. XOR -> 0xFF00.
- Undefined opcodes 1100..1111 with nonzero operands -> out=0, zero=1. With ALU_OUT_REG_EN, check the 1-cycle latency and that reset asserted mid-stream clears the outputs without waiting for a clock edge.
